proc_control_fsm: RTL and testbench

Multi-cycle control unit for the 16-bit, 8-register bus datapath. It latches a 9-bit instruction, then sequences the bus multiplexer selects (register number, ALU result `G`, immediate), register write enables and the ALU over one to three execute steps. It sits beside the register file, bus multiplexer and ALU and is their only source of control.

---
 rtl/proc_pkg.sv | 27 ++
 rtl/dec3to8.sv | 15 +
 rtl/proc_control_fsm.sv | 119 +++++++++++
 tb/tb_proc_control_fsm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the bus-datapath control unit: opcodes, IR field
// positions and the FSM state type.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Instruction layout: III XXX YYY
  localparam int unsigned OP_MSB  = 8;
  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned RX_MSB  = 5;
  localparam int unsigned RX_LSB  = 3;
  localparam int unsigned RY_MSB  = 2;
  localparam int unsigned RY_LSB  = 0;
  // Opcode LSB distinguishes add (0) from sub (1)
  localparam int unsigned SUB_BIT = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StT1   = 2'd1,
    StT2   = 2'd2,
    StT3   = 2'd3
  } state_e;

endpackage

// File: rtl/dec3to8.sv
// 3-bit to one-hot 8 decoder with enable; all outputs low when disabled.
module dec3to8 (
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic [7:0] out_o
);

  always_comb begin
    out_o = '0;
    if (en_i) begin
      out_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Multi-cycle control unit: latches an instruction in IDLE, then drives bus
// selects, register write enables and ALU controls over T1..T3.
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int unsigned IW   = 9,
  parameter int unsigned NREG = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [IW-1:0]   din,
  output logic [2:0]      regNumSelect,
  output logic            regSelEn,
  output logic            Rselect,
  output logic            Iselect,
  output logic [NREG-1:0] regIn,
  output logic            aIn,
  output logic            gIn,
  output logic            addSub,
  output logic            done,
  output logic            illegal,
  output logic            busy
);

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          wr_en;

  logic [2:0] op, rx, ry;
  assign op = ir_q[OP_MSB:OP_LSB];
  assign rx = ir_q[RX_MSB:RX_LSB];
  assign ry = ir_q[RY_MSB:RY_LSB];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    regNumSelect = 3'b000;
    regSelEn     = 1'b0;
    Rselect      = 1'b0;
    Iselect      = 1'b0;
    wr_en        = 1'b0;
    aIn          = 1'b0;
    gIn          = 1'b0;
    addSub       = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          ir_d    = din;
          state_d = StT1;
        end
      end
      StT1: begin
        case (op)
          OP_MV: begin
            regSelEn     = 1'b1;
            regNumSelect = ry;
            wr_en        = 1'b1;
            done         = 1'b1;
            state_d      = StIdle;
          end
          OP_MVI: begin
            // Immediate comes straight off din this cycle via the sign extender
            Iselect = 1'b1;
            wr_en   = 1'b1;
            done    = 1'b1;
            state_d = StIdle;
          end
          OP_ADD, OP_SUB: begin
            regSelEn     = 1'b1;
            regNumSelect = rx;
            aIn          = 1'b1;
            state_d      = StT2;
          end
          default: begin
            done    = 1'b1;
            illegal = 1'b1;
            state_d = StIdle;
          end
        endcase
      end
      StT2: begin
        regSelEn     = 1'b1;
        regNumSelect = ry;
        gIn          = 1'b1;
        addSub       = ir_q[SUB_BIT];
        state_d      = StT3;
      end
      StT3: begin
        Rselect = 1'b1;
        wr_en   = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  assign busy = (state_q != StIdle);

  dec3to8 u_dec_regin (
    .en_i  (wr_en),
    .sel_i (rx),
    .out_o (regIn)
  );

endmodule

// File: tb/tb_proc_control_fsm.sv
// Scoreboard bench for proc_control_fsm: stimulus queues expected output
// vectors per busy cycle; a negedge monitor pops and compares them.
module tb_proc_control_fsm;

  logic       clock, reset, run;
  logic [8:0] din;
  logic [2:0] regNumSelect;
  logic       regSelEn, Rselect, Iselect;
  logic [7:0] regIn;
  logic       aIn, gIn, addSub, done, illegal, busy;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];

  proc_control_fsm #(.IW(9), .NREG(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .din          (din),
    .regNumSelect (regNumSelect),
    .regSelEn     (regSelEn),
    .Rselect      (Rselect),
    .Iselect      (Iselect),
    .regIn        (regIn),
    .aIn          (aIn),
    .gIn          (gIn),
    .addSub       (addSub),
    .done         (done),
    .illegal      (illegal),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [19:0] act_vec();
    return {regNumSelect, regSelEn, Rselect, Iselect, regIn, aIn, gIn, addSub, done,
            illegal, busy};
  endfunction

  function automatic logic [19:0] ev(input logic [2:0] rns, input logic rse, input logic rsel,
                                     input logic isel, input logic [7:0] rin, input logic ain,
                                     input logic gin, input logic asub, input logic dn,
                                     input logic ill);
    return {rns, rse, rsel, isel, rin, ain, gin, asub, dn, ill, 1'b1};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: every busy cycle is one output beat to score
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (32'($countones({regSelEn, Rselect, Iselect})) > 1) begin
        errors++;
        $display("FAIL bus_onehot: sources %b", {regSelEn, Rselect, Iselect});
      end
      if (busy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %b expected no busy cycle", act_vec());
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          if (act_vec() !== e) begin
            errors++;
            $display("FAIL beat: got %b expected %b", act_vec(), e);
          end
        end
      end
    end
  end

  task automatic start(input logic [8:0] instr);
    @(posedge clock); #1;
    run = 1'b1;
    din = instr;
    @(posedge clock); #1;
    run = 1'b0;
  endtask

  task automatic drain_and_idle(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clock); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d beats pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clock); #1;
    check({name, "_idle"}, act_vec(), 20'h0);
  endtask

  initial begin
    logic [4:0] done_seq, busy_seq;
    reset = 1'b1;
    run   = 1'b0;
    din   = 9'h0;
    #2;
    check("reset_outputs", act_vec(), 20'h0);
    @(posedge clock); #1;
    check("reset_held_idle", act_vec(), 20'h0);
    @(negedge clock);
    reset = 1'b0;

    // mv r3,r5
    exp_q.push_back(ev(3'b101, 1, 0, 0, 8'b0000_1000, 0, 0, 0, 1, 0));
    start(9'b000_011_101);
    drain_and_idle("mv");

    // mvi r1 with immediate 0x1F0 on din in T1
    exp_q.push_back(ev(3'b000, 0, 0, 1, 8'b0000_0010, 0, 0, 0, 1, 0));
    start(9'b001_001_000);
    din = 9'h1F0;
    drain_and_idle("mvi");

    // sub r4,r6
    exp_q.push_back(ev(3'b100, 1, 0, 0, 8'b0000_0000, 1, 0, 0, 0, 0));
    exp_q.push_back(ev(3'b110, 1, 0, 0, 8'b0000_0000, 0, 1, 1, 0, 0));
    exp_q.push_back(ev(3'b000, 0, 1, 0, 8'b0001_0000, 0, 0, 0, 1, 0));
    start(9'b011_100_110);
    drain_and_idle("sub");

    // illegal opcodes 101 and 111
    exp_q.push_back(ev(3'b000, 0, 0, 0, 8'b0000_0000, 0, 0, 0, 1, 1));
    start(9'b101_010_010);
    drain_and_idle("ill101");
    exp_q.push_back(ev(3'b000, 0, 0, 0, 8'b0000_0000, 0, 0, 0, 1, 1));
    start(9'b111_000_001);
    drain_and_idle("ill111");

    // add r2,r2 with a run pulse during T2 that must be ignored
    exp_q.push_back(ev(3'b010, 1, 0, 0, 8'b0000_0000, 1, 0, 0, 0, 0));
    exp_q.push_back(ev(3'b010, 1, 0, 0, 8'b0000_0000, 0, 1, 0, 0, 0));
    exp_q.push_back(ev(3'b000, 0, 1, 0, 8'b0000_0100, 0, 0, 0, 1, 0));
    start(9'b010_010_010);
    @(posedge clock); #1;
    run = 1'b1;
    din = 9'b101_000_000;
    @(posedge clock); #1;
    run = 1'b0;
    drain_and_idle("add_runT2");

    // Reset in T2 of add r0,r7
    exp_q.push_back(ev(3'b000, 1, 0, 0, 8'b0000_0000, 1, 0, 0, 0, 0));
    exp_q.push_back(ev(3'b111, 1, 0, 0, 8'b0000_0000, 0, 1, 0, 0, 0));
    start(9'b010_000_111);
    @(posedge clock);
    @(negedge clock); #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_pre: %0d beats pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    reset = 1'b1;
    #1;
    check("abort_async", act_vec(), 20'h0);
    @(posedge clock); #1;
    check("abort_held", act_vec(), 20'h0);
    @(negedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("abort_released_idle", act_vec(), 20'h0);

    // Back-to-back add r1,r3 then mv r6,r1 with run held high
    exp_q.push_back(ev(3'b001, 1, 0, 0, 8'b0000_0000, 1, 0, 0, 0, 0));
    exp_q.push_back(ev(3'b011, 1, 0, 0, 8'b0000_0000, 0, 1, 0, 0, 0));
    exp_q.push_back(ev(3'b000, 0, 1, 0, 8'b0000_0010, 0, 0, 0, 1, 0));
    exp_q.push_back(ev(3'b001, 1, 0, 0, 8'b0100_0000, 0, 0, 0, 1, 0));
    @(posedge clock); #1;
    run = 1'b1;
    din = 9'b010_001_011;
    done_seq = '0;
    busy_seq = '0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      if (k == 2) din = 9'b000_110_001;
      if (k == 4) run = 1'b0;
      @(negedge clock); #1;
      done_seq[k] = done;
      busy_seq[k] = busy;
    end
    check("b2b_done_cycles", {15'h0, done_seq}, {15'h0, 5'b10100});
    check("b2b_busy_cycles", {15'h0, busy_seq}, {15'h0, 5'b10111});
    drain_and_idle("b2b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
